// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Central hazard controller for the 5-stage MIPS pipeline. It covers the
// hazards that forwarding cannot resolve:
//   - load-use stalls
//   - branch flushes
//   - sequencing of the shared multi-cycle mul/div unit: destination
//     scoreboard and ownership of the single register-file write port
//
// Optional feature, enabled with the macro HAZ_STALL_COUNT_EN:
//   adds a saturating 16-bit stallCount output. It counts the cycles in
//   which pcWrite is low.
//
// Parameters:
//   MD_LATENCY  number of BUSY cycles of the mul/div unit (1..15)
//
// Ports:
//   clk, rst          pipeline clock, asynchronous active-high reset
//   IdRs/IdRt         source fields of the instruction in ID
//   IdUsesRs/IdUsesRt ID instruction really reads rs / rt
//   IdMulDiv          ID instruction is mul/div
//   IdExRt/IdExRd     rt / destination of the instruction in EX
//   IdExMemRead       EX instruction is a load
//   IdExMulDiv        EX instruction is mul/div (start request)
//   branchTaken       EX branch/jump resolved taken
//   pcWrite           PC load enable
//   ifIdWrite         IF/ID load enable
//   ifIdFlush         IF/ID clear
//   idExFlush         insert a bubble into ID/EX
//   pipeFreeze        hold every pipeline register
//   mdBusy            mul/div FSM is not idle
//   mdDone            mul/div result owns the write port this cycle
//   stallCount        (HAZ_STALL_COUNT_EN only) saturating stall-cycle counter
//   mdDest            registered mul/div destination
//
// Handshake: IdExMulDiv is a one-shot start request. It is accepted only in
// IDLE. Because the pipeline is frozen during DONE, a start held in EX at that
// point is re-presented and accepted on the following IDLE cycle.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
  parameter int unsigned MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  IdRs,
  input  logic [4:0]  IdRt,
  input  logic        IdUsesRs,
  input  logic        IdUsesRt,
  input  logic        IdMulDiv,
  input  logic [4:0]  IdExRt,
  input  logic [4:0]  IdExRd,
  input  logic        IdExMemRead,
  input  logic        IdExMulDiv,
  input  logic        branchTaken,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        pipeFreeze,
  output logic        mdBusy,
  output logic        mdDone,
`ifdef HAZ_STALL_COUNT_EN
  output logic [15:0] stallCount,
`endif
  output logic [4:0]  mdDest
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] dest_q, dest_d;

  logic load_use;
  logic md_raw;
  logic md_struct;

  // ---------------------------------------------------------------------------
  // Mul/div sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    case (state_q)
      ST_IDLE: begin
        if (IdExMulDiv) begin
          cnt_d   = 4'(MD_LATENCY - 1);
          dest_d  = IdExRd;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // The count is loaded with MD_LATENCY-1 and leaves at zero, so BUSY
        // lasts exactly MD_LATENCY cycles.
        if (cnt_q == 4'd0) state_d = ST_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      dest_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
    end
  end

  assign mdBusy = (state_q != ST_IDLE);
  assign mdDone = (state_q == ST_DONE);
  assign mdDest = dest_q;

  // ---------------------------------------------------------------------------
  // Hazard terms. Register $0 never creates a dependency.
  // ---------------------------------------------------------------------------
  assign load_use = IdExMemRead && (IdExRt != 5'd0) &&
                    ((IdUsesRs && (IdRs == IdExRt)) ||
                     (IdUsesRt && (IdRt == IdExRt)));

  // The dependency is held through DONE as well. It is released only in IDLE,
  // when the register file already holds the result.
  assign md_raw = mdBusy && (dest_q != 5'd0) &&
                  ((IdUsesRs && (IdRs == dest_q)) ||
                   (IdUsesRt && (IdRt == dest_q)));

  // Only one mul/div may be in flight.
  assign md_struct = IdMulDiv && (mdBusy || IdExMulDiv);

  // ---------------------------------------------------------------------------
  // Output priority: DONE freeze > branch flush > stall > run
  // ---------------------------------------------------------------------------
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    pipeFreeze = 1'b0;
    if (state_q == ST_DONE) begin
      // The write port belongs to mul/div. Everything holds, so a taken branch
      // in EX is re-presented on the next cycle.
      pipeFreeze = 1'b1;
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
    end else if (branchTaken) begin
      // The ID instruction is squashed, so its stall reasons do not matter.
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (load_use || md_raw || md_struct) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
    end
  end

`ifdef HAZ_STALL_COUNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (!pcWrite && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] IdRs, IdRt, IdExRt, IdExRd;
  logic       IdUsesRs, IdUsesRt, IdMulDiv, IdExMemRead, IdExMulDiv, branchTaken;

  logic       pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze, mdBusy, mdDone;
  logic [4:0] mdDest;
  logic       pcWrite_l1, ifIdWrite_l1, ifIdFlush_l1, idExFlush_l1, pipeFreeze_l1;
  logic       mdBusy_l1, mdDone_l1;
  logic [4:0] mdDest_l1;
`ifdef HAZ_STALL_COUNT_EN
  logic [15:0] stallCount, stallCount_l1;
`endif

  always #5 clk = ~clk;

  hazard_scoreboard #(.MD_LATENCY(4)) u_dut (
    .clk(clk), .rst(rst),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdMulDiv(IdMulDiv), .IdExRt(IdExRt), .IdExRd(IdExRd),
    .IdExMemRead(IdExMemRead), .IdExMulDiv(IdExMulDiv), .branchTaken(branchTaken),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExFlush(idExFlush), .pipeFreeze(pipeFreeze), .mdBusy(mdBusy),
    .mdDone(mdDone),
`ifdef HAZ_STALL_COUNT_EN
    .stallCount(stallCount),
`endif
    .mdDest(mdDest)
  );

  hazard_scoreboard #(.MD_LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .IdRs(IdRs), .IdRt(IdRt), .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt),
    .IdMulDiv(IdMulDiv), .IdExRt(IdExRt), .IdExRd(IdExRd),
    .IdExMemRead(IdExMemRead), .IdExMulDiv(IdExMulDiv), .branchTaken(branchTaken),
    .pcWrite(pcWrite_l1), .ifIdWrite(ifIdWrite_l1), .ifIdFlush(ifIdFlush_l1),
    .idExFlush(idExFlush_l1), .pipeFreeze(pipeFreeze_l1), .mdBusy(mdBusy_l1),
    .mdDone(mdDone_l1),
`ifdef HAZ_STALL_COUNT_EN
    .stallCount(stallCount_l1),
`endif
    .mdDest(mdDest_l1)
  );

  // ---------------- scoreboard ----------------
  // Expected word: {pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze,
  //                 mdBusy, mdDone, mdDest}
  localparam logic [6:0] F_IDLE   = 7'b1100000;
  localparam logic [6:0] F_STALL  = 7'b0001000;
  localparam logic [6:0] F_BUSY   = 7'b1100010;
  localparam logic [6:0] F_BSTALL = 7'b0001010;
  localparam logic [6:0] F_DONE   = 7'b0000111;
  localparam logic [6:0] F_FLUSH  = 7'b1111000;

  logic [11:0] exp_q[$];
  logic [11:0] got, e;
  logic [4:0]  dest_m;
  int          total = 0;
  int          bad   = 0;

  function automatic logic [11:0] obs0();
    return {pcWrite, ifIdWrite, ifIdFlush, idExFlush, pipeFreeze, mdBusy, mdDone, mdDest};
  endfunction

  function automatic logic [11:0] obs1();
    return {pcWrite_l1, ifIdWrite_l1, ifIdFlush_l1, idExFlush_l1, pipeFreeze_l1,
            mdBusy_l1, mdDone_l1, mdDest_l1};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int rs, input int rt, input int urs, input int urt,
                       input int imd, input int exrt, input int exrd,
                       input int memrd, input int exmd, input int br);
    IdRs        = 5'(rs);
    IdRt        = 5'(rt);
    IdUsesRs    = (urs != 0);
    IdUsesRt    = (urt != 0);
    IdMulDiv    = (imd != 0);
    IdExRt      = 5'(exrt);
    IdExRd      = 5'(exrd);
    IdExMemRead = (memrd != 0);
    IdExMulDiv  = (exmd != 0);
    branchTaken = (br != 0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    exp_q.push_back({F_IDLE, 5'd0});
    exp_q.push_back({F_IDLE, 5'd0});
    got = obs0(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_l4 got=%h exp=%h", got, e); end
    got = obs1(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_l1 got=%h exp=%h", got, e); end
`ifdef HAZ_STALL_COUNT_EN
    total++;
    if (stallCount !== 16'd0) begin
      bad++; $display("FAIL reset_stallcount got=%h exp=0000", stallCount);
    end
`endif
    rst = 1'b0;
    dest_m = 5'd0;
    @(posedge clk); #1;
    exp_q.push_back({F_IDLE, 5'd0});
    @(negedge clk);
    got = obs0(); e = exp_q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_release got=%h exp=%h", got, e); end
  endtask

  task automatic test_load_use();
    logic s;
    int rs, rt, urs, urt, exrt, memrd;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      s = 1'b0;
      case (k)
        0: begin drive(8, 0, 1, 0, 0, 8, 0, 1, 0, 0); s = 1'b1; end
        1: begin drive(0, 0, 1, 0, 0, 0, 0, 1, 0, 0); s = 1'b0; end  // $0 is never a dependency
        2: begin drive(3, 9, 0, 1, 0, 9, 0, 1, 0, 0); s = 1'b1; end
        default: begin drive(9, 9, 0, 0, 0, 9, 0, 1, 0, 0); s = 1'b0; end
      endcase
      exp_q.push_back({(s ? F_STALL : F_IDLE), dest_m});
      @(negedge clk);
      got = obs0(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL load_use_dir k=%0d got=%h exp=%h", k, got, e); end
    end
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      rs = $urandom_range(0, 3); rt = $urandom_range(0, 3);
      urs = $urandom_range(0, 1); urt = $urandom_range(0, 1);
      exrt = $urandom_range(0, 3); memrd = $urandom_range(0, 1);
      drive(rs, rt, urs, urt, 0, exrt, 0, memrd, 0, 0);
      s = (memrd != 0) && (exrt != 0) &&
          (((urs != 0) && (rs == exrt)) || ((urt != 0) && (rt == exrt)));
      exp_q.push_back({(s ? F_STALL : F_IDLE), dest_m});
      @(negedge clk);
      got = obs0(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL load_use_rnd k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_muldiv();
    // start at k=0, BUSY k=1..4, DONE k=5, IDLE k=6; rt=5 read throughout
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        drive(0, 5, 0, 1, 0, 0, 5, 0, 1, 0);
        exp_q.push_back({F_IDLE, dest_m});
        dest_m = 5'd5;
      end else begin
        drive(0, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        if (k <= 4)      exp_q.push_back({F_BSTALL, 5'd5});
        else if (k == 5) exp_q.push_back({F_DONE, 5'd5});
        else             exp_q.push_back({F_IDLE, 5'd5});
      end
      @(negedge clk);
      got = obs0(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL muldiv k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_struct();
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        drive(0, 0, 0, 0, 1, 0, 6, 0, 1, 0);
        exp_q.push_back({F_STALL, dest_m});
        dest_m = 5'd6;
      end else if (k <= 4) begin
        drive(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        exp_q.push_back({F_BSTALL, 5'd6});
      end else if (k == 5) begin
        // start request held during DONE must not be taken
        drive(0, 0, 0, 0, 0, 0, 7, 0, 1, 0);
        exp_q.push_back({F_DONE, 5'd6});
      end else if (k == 6) begin
        drive(0, 0, 0, 0, 0, 0, 7, 0, 1, 0);
        exp_q.push_back({F_IDLE, 5'd6});
        dest_m = 5'd7;
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        if (k <= 10)      exp_q.push_back({F_BUSY, 5'd7});
        else if (k == 11) exp_q.push_back({F_DONE, 5'd7});
        else              exp_q.push_back({F_IDLE, 5'd7});
      end
      @(negedge clk);
      got = obs0(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL struct k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_branch();
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        drive(8, 0, 1, 0, 0, 8, 0, 1, 0, 1);          // branch beats load-use
        exp_q.push_back({F_FLUSH, dest_m});
      end else if (k == 1) begin
        drive(0, 0, 0, 0, 0, 0, 9, 0, 1, 0);
        exp_q.push_back({F_IDLE, dest_m});
        dest_m = 5'd9;
      end else if (k <= 5) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back({F_BUSY, 5'd9});
      end else if (k == 6) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // branch during DONE
        exp_q.push_back({F_DONE, 5'd9});
      end else if (k == 7) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);          // re-presented
        exp_q.push_back({F_FLUSH, 5'd9});
      end else begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back({F_IDLE, 5'd9});
      end
      @(negedge clk);
      got = obs0(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL branch k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  task automatic test_reset_mid_busy();
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        drive(0, 0, 0, 0, 0, 0, 10, 0, 1, 0);
        exp_q.push_back({F_IDLE, dest_m});
        dest_m = 5'd10;
      end else if (k == 1) begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back({F_BUSY, 5'd10});
      end else if (k == 2) begin
        rst = 1'b1;
        exp_q.push_back({F_IDLE, 5'd0});
        dest_m = 5'd0;
      end else begin
        exp_q.push_back({F_IDLE, 5'd0});
      end
      @(negedge clk);
      got = obs0(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL reset_busy k=%0d got=%h exp=%h", k, got, e); end
`ifdef HAZ_STALL_COUNT_EN
      if (k == 2) begin
        total++;
        if (stallCount !== 16'd0) begin
          bad++; $display("FAIL reset_busy_stallcount got=%h exp=0000", stallCount);
        end
      end
`endif
      if (k == 2) rst = 1'b0;
    end
  endtask

`ifdef HAZ_STALL_COUNT_EN
  task automatic test_stall_count();
    logic [15:0] cq[$];
    logic [15:0] ce;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    drive(8, 0, 1, 0, 0, 8, 0, 1, 0, 0);              // continuous load-use stall
    repeat (3) @(posedge clk);
    cq.push_back(16'd3);
    @(negedge clk);
    ce = cq.pop_front(); total++;
    if (stallCount !== ce) begin bad++; $display("FAIL stallcount_3 got=%h exp=%h", stallCount, ce); end
    repeat (65540) @(posedge clk);
    cq.push_back(16'hFFFF);
    @(negedge clk);
    ce = cq.pop_front(); total++;
    if (stallCount !== ce) begin bad++; $display("FAIL stallcount_sat got=%h exp=%h", stallCount, ce); end
    repeat (2) @(posedge clk);
    cq.push_back(16'hFFFF);
    @(negedge clk);
    ce = cq.pop_front(); total++;
    if (stallCount !== ce) begin bad++; $display("FAIL stallcount_hold got=%h exp=%h", stallCount, ce); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_boundary();
    // MD_LATENCY=1 instance: start k=0, BUSY k=1, DONE k=2, IDLE k=3
    @(negedge clk); rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        drive(3, 0, 1, 0, 0, 0, 3, 0, 1, 0);
        exp_q.push_back({F_IDLE, 5'd0});
      end else begin
        drive(3, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        if (k == 1)      exp_q.push_back({F_BSTALL, 5'd3});
        else if (k == 2) exp_q.push_back({F_DONE, 5'd3});
        else             exp_q.push_back({F_IDLE, 5'd3});
      end
      @(negedge clk);
      got = obs1(); e = exp_q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL boundary_l1 k=%0d got=%h exp=%h", k, got, e); end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_load_use();
    test_muldiv();
    test_struct();
    test_branch();
    test_reset_mid_busy();
`ifdef HAZ_STALL_COUNT_EN
    test_stall_count();
`endif
    test_boundary();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
